// File: rtl/i2c_slave.sv
// i2c_slave: I2C target with 7-bit address match, byte write/read user interface.
// Optional build macro I2C_GLITCH_FILTER_EN adds a 3-sample majority filter on
// the synchronised scl/sda before edge detection (rejects 1-clock pulses).
//
// state | meaning
// ------+-----------------------------------------------------------
// 0     | IDLE      - bus free, waiting for START
// 1     | ADDR      - shifting 7 address bits + R/W
// 2     | ADDR_ACK  - driving ACK for a matched address
// 3     | WR_DATA   - shifting a write byte from the master
// 4     | WR_ACK    - driving ACK for a write byte
// 5     | RD_DATA   - driving a read byte onto sda
// 6     | RD_ACK    - sampling master ACK/NACK of a read byte
// 7     | WAIT_STOP - not addressed / NACKed, ignore until START/STOP
`timescale 1ns/1ps

module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       scl,
    inout  wire        sda,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       busy,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_ADDR_ACK  = 4'd2,
        ST_WR_DATA   = 4'd3,
        ST_WR_ACK    = 4'd4,
        ST_RD_DATA   = 4'd5,
        ST_RD_ACK    = 4'd6,
        ST_WAIT_STOP = 4'd7
    } state_e;

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_c;
    logic                   sda_c;
    logic                   scl_prev_q;
    logic                   sda_prev_q;
    logic                   scl_rise;
    logic                   scl_fall;
    logic                   start_det;
    logic                   stop_det;

    // Synchronisers reset to the idle bus level so reset release never looks like an edge
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda};
        end
    end

`ifdef I2C_GLITCH_FILTER_EN
    logic [1:0] scl_hist_q;
    logic [1:0] sda_hist_q;
    logic       scl_flt_q;
    logic       sda_flt_q;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Majority of the last three synchronised samples; a single-clock pulse never wins
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            scl_hist_q <= '1;
            sda_hist_q <= '1;
            scl_flt_q  <= 1'b1;
            sda_flt_q  <= 1'b1;
        end else begin
            scl_hist_q <= {scl_hist_q[0], scl_sync_q[SYNC_STAGES-1]};
            sda_hist_q <= {sda_hist_q[0], sda_sync_q[SYNC_STAGES-1]};
            scl_flt_q  <= maj3(scl_sync_q[SYNC_STAGES-1], scl_hist_q[0], scl_hist_q[1]);
            sda_flt_q  <= maj3(sda_sync_q[SYNC_STAGES-1], sda_hist_q[0], sda_hist_q[1]);
        end
    end

    assign scl_c = scl_flt_q;
    assign sda_c = sda_flt_q;
`else
    assign scl_c = scl_sync_q[SYNC_STAGES-1];
    assign sda_c = sda_sync_q[SYNC_STAGES-1];
`endif

    // Previous-sample register for edge and bus-condition detection
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_prev_q <= scl_c;
            sda_prev_q <= sda_c;
        end
    end

    assign scl_rise  =  scl_c & ~scl_prev_q;
    assign scl_fall  = ~scl_c &  scl_prev_q;
    assign start_det =  scl_c &  scl_prev_q &  sda_prev_q & ~sda_c;
    assign stop_det  =  scl_c &  scl_prev_q & ~sda_prev_q &  sda_c;

    state_e     state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] cnt_q, cnt_d;
    logic       rw_q, rw_d;
    logic       ack_pend_q, ack_pend_d;
    logic       oe_q, oe_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_req_q, tx_req_d;
    logic       busy_q, busy_d;
    logic [7:0] shifted;

    assign shifted = {shift_q[6:0], sda_c};

    // Next-state and output decode; ack_pend marks "ACK/reload due on the coming scl fall"
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        rw_d       = rw_q;
        ack_pend_d = ack_pend_q;
        oe_d       = oe_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_req_d   = 1'b0;
        busy_d     = busy_q;

        if (stop_det) begin
            state_d    = ST_IDLE;
            oe_d       = 1'b0;
            busy_d     = 1'b0;
            ack_pend_d = 1'b0;
            cnt_d      = 3'd0;
        end else if (start_det) begin
            state_d    = ST_ADDR;
            oe_d       = 1'b0;
            ack_pend_d = 1'b0;
            cnt_d      = 3'd0;
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_d = shifted;
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            if (shift_q[6:0] == SLAVE_ADDR) begin
                                busy_d     = 1'b1;
                                rw_d       = sda_c;
                                tx_req_d   = sda_c;
                                ack_pend_d = 1'b1;
                            end else begin
                                state_d = ST_WAIT_STOP;
                            end
                        end
                    end else if (scl_fall && ack_pend_q) begin
                        oe_d       = 1'b1;
                        ack_pend_d = 1'b0;
                        state_d    = ST_ADDR_ACK;
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        cnt_d = 3'd0;
                        if (rw_q) begin
                            shift_d = tx_data;
                            oe_d    = ~tx_data[7];
                            state_d = ST_RD_DATA;
                        end else begin
                            oe_d    = 1'b0;
                            state_d = ST_WR_DATA;
                        end
                    end
                end
                ST_WR_DATA: begin
                    if (scl_rise) begin
                        shift_d = shifted;
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            rx_data_d  = shifted;
                            rx_valid_d = 1'b1;
                            ack_pend_d = 1'b1;
                        end
                    end else if (scl_fall && ack_pend_q) begin
                        oe_d       = 1'b1;
                        ack_pend_d = 1'b0;
                        state_d    = ST_WR_ACK;
                    end
                end
                ST_WR_ACK: begin
                    if (scl_fall) begin
                        oe_d    = 1'b0;
                        cnt_d   = 3'd0;
                        state_d = ST_WR_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (scl_fall) begin
                        if (cnt_q == 3'd7) begin
                            oe_d    = 1'b0;
                            cnt_d   = 3'd0;
                            state_d = ST_RD_ACK;
                        end else begin
                            shift_d = {shift_q[6:0], 1'b0};
                            oe_d    = ~shift_q[6];
                            cnt_d   = cnt_q + 3'd1;
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise) begin
                        if (!sda_c) begin
                            tx_req_d   = 1'b1;
                            ack_pend_d = 1'b1;
                        end else begin
                            oe_d    = 1'b0;
                            state_d = ST_WAIT_STOP;
                        end
                    end else if (scl_fall && ack_pend_q) begin
                        shift_d    = tx_data;
                        oe_d       = ~tx_data[7];
                        cnt_d      = 3'd0;
                        ack_pend_d = 1'b0;
                        state_d    = ST_RD_DATA;
                    end
                end
                ST_WAIT_STOP: begin
                    oe_d = 1'b0;
                end
                default: begin
                    oe_d = 1'b0;
                end
            endcase
        end
    end

    // FSM and registered outputs; async reset releases sda immediately
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            shift_q    <= 8'h00;
            cnt_q      <= 3'd0;
            rw_q       <= 1'b0;
            ack_pend_q <= 1'b0;
            oe_q       <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            rw_q       <= rw_d;
            ack_pend_q <= ack_pend_d;
            oe_q       <= oe_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_req_q   <= tx_req_d;
            busy_q     <= busy_d;
        end
    end

    assign sda      = oe_q ? 1'b0 : 1'bz;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign tx_req   = tx_req_q;
    assign busy     = busy_q;
    assign state    = state_q;

endmodule

// File: tb/tb_i2c_slave.sv
// tb_i2c_slave: bit-level I2C master driving i2c_slave; table vectors plus
// randomized transactions checked against a transaction-level expectation model.
`timescale 1ns/1ps

module tb_i2c_slave;

    localparam logic [6:0] SLV = 7'h50;
    localparam int         Q   = 100;

    logic       clock   = 1'b0;
    logic       reset   = 1'b0;
    logic       scl     = 1'b1;
    logic       m_oe    = 1'b0;
    logic [7:0] tx_data = 8'h00;
    wire        sda;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_req;
    logic       busy;
    logic [3:0] state;

    assign sda = m_oe ? 1'b0 : 1'bz;
    pullup (sda);

    always #5 clock = ~clock;

    i2c_slave #(.SLAVE_ADDR(SLV), .SYNC_STAGES(2)) dut (
        .clock    (clock),
        .reset    (reset),
        .scl      (scl),
        .sda      (sda),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_req   (tx_req),
        .busy     (busy),
        .state    (state)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: everything here only ever grows, the test reads deltas
    logic [7:0] rx_q[$];
    int         tx_cnt  = 0;
    int         low_cnt = 0;
    always @(negedge clock) begin
        if (rx_valid) rx_q.push_back(rx_data);
        if (tx_req) tx_cnt++;
        if (sda === 1'b0 && !m_oe) low_cnt++;
    end

    // ---------------- bus master primitives ----------------
    task automatic bit_xfer(input logic v, output logic s);
        m_oe = ~v;
        #Q;
        scl = 1'b1;
        #Q;
        s = (sda === 1'b0) ? 1'b0 : 1'b1;
        #Q;
        scl = 1'b0;
        #Q;
    endtask

    task automatic do_start();
        if (scl == 1'b0) begin
            m_oe = 1'b0;
            #Q;
            scl = 1'b1;
            #Q;
        end
        m_oe = 1'b1;
        #Q;
        scl = 1'b0;
        #Q;
    endtask

    task automatic do_stop();
        m_oe = 1'b1;
        #Q;
        scl = 1'b1;
        #Q;
        m_oe = 1'b0;
        #Q;
        #Q;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic d;
        for (int i = 7; i >= 0; i--) bit_xfer(b[i], d);
        bit_xfer(1'b1, ack);
    endtask

    // Transaction arguments/results live at module scope
    logic [7:0] txb[4];
    logic       obs_aack;
    logic       obs_dack[4];
    logic [7:0] obs_rd[4];
    logic [3:0] obs_state;
    logic       obs_busy;

    // Master reads ACK every byte except the last, which it NACKs
    task automatic run_txn(input logic [6:0] a, input logic rw, input int n,
                           input logic with_start, input logic with_stop);
        logic       d;
        logic [7:0] tmp;
        if (rw) tx_data = txb[0];
        if (with_start) do_start();
        send_byte({a, rw}, obs_aack);
        obs_busy = busy;
        for (int k = 0; k < n; k++) begin
            if (!rw) begin
                send_byte(txb[k], obs_dack[k]);
            end else begin
                for (int i = 7; i >= 0; i--) begin
                    bit_xfer(1'b1, d);
                    tmp[i] = d;
                end
                obs_rd[k] = tmp;
                if (k + 1 < n) tx_data = txb[k+1];
                bit_xfer(k == n - 1, d);
            end
        end
        obs_state = state;
        if (with_stop) do_stop();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [6:0] addr;
        logic       rw;
        int         n;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       exp_aack;
        logic       exp_busy;
        int         exp_rx;
        int         exp_txreq;
        logic [3:0] exp_state;
    } vec_t;

    vec_t tbl[3];

    initial begin
        int         rx_base;
        int         tx_base;
        int         low_base;
        logic       d;
        logic [6:0] a;
        logic       rw;
        int         n;
        logic       match;

        tbl[0] = '{addr: 7'h50, rw: 1'b0, n: 2, d0: 8'hA5, d1: 8'h3C, exp_aack: 1'b0,
                   exp_busy: 1'b1, exp_rx: 2, exp_txreq: 0, exp_state: 4'd3};
        tbl[1] = '{addr: 7'h51, rw: 1'b0, n: 0, d0: 8'h00, d1: 8'h00, exp_aack: 1'b1,
                   exp_busy: 1'b0, exp_rx: 0, exp_txreq: 0, exp_state: 4'd7};
        tbl[2] = '{addr: 7'h50, rw: 1'b1, n: 2, d0: 8'h96, d1: 8'h0F, exp_aack: 1'b0,
                   exp_busy: 1'b1, exp_rx: 0, exp_txreq: 2, exp_state: 4'd7};

        #200;
        check("reset_state", state, 4'd0);
        check("reset_busy", busy, 1'b0);
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_sda", sda, 1'b1);
        reset = 1'b1;
        #200;

        foreach (tbl[v]) begin
            txb[0]   = tbl[v].d0;
            txb[1]   = tbl[v].d1;
            rx_base  = rx_q.size();
            tx_base  = tx_cnt;
            low_base = low_cnt;
            run_txn(tbl[v].addr, tbl[v].rw, tbl[v].n, 1'b1, 1'b1);
            check($sformatf("tbl%0d_addr_ack", v), obs_aack, tbl[v].exp_aack);
            check($sformatf("tbl%0d_busy", v), obs_busy, tbl[v].exp_busy);
            check($sformatf("tbl%0d_state_pre_stop", v), obs_state, tbl[v].exp_state);
            check($sformatf("tbl%0d_rx_count", v), rx_q.size() - rx_base, tbl[v].exp_rx);
            check($sformatf("tbl%0d_txreq_count", v), tx_cnt - tx_base, tbl[v].exp_txreq);
            if (tbl[v].exp_rx == 2 && rx_q.size() - rx_base == 2) begin
                check($sformatf("tbl%0d_rx0", v), rx_q[rx_base], tbl[v].d0);
                check($sformatf("tbl%0d_rx1", v), rx_q[rx_base+1], tbl[v].d1);
            end
            for (int k = 0; k < tbl[v].n; k++) begin
                if (tbl[v].rw) check($sformatf("tbl%0d_rd%0d", v, k), obs_rd[k], txb[k]);
                else           check($sformatf("tbl%0d_dack%0d", v, k), obs_dack[k], 1'b0);
            end
            if (tbl[v].exp_aack) check($sformatf("tbl%0d_sda_never_low", v), low_cnt - low_base, 0);
            check($sformatf("tbl%0d_state_post_stop", v), state, 4'd0);
            check($sformatf("tbl%0d_busy_post_stop", v), busy, 1'b0);
        end

        // Repeated START: write 0x11, then re-address for a read
        rx_base = rx_q.size();
        txb[0]  = 8'h11;
        run_txn(SLV, 1'b0, 1, 1'b1, 1'b0);
        check("rs_wr_ack", obs_dack[0], 1'b0);
        do_start();
        check("rs_state_addr", state, 4'd1);
        txb[0] = 8'hC3;
        run_txn(SLV, 1'b1, 1, 1'b0, 1'b1);
        check("rs_rd_addr_ack", obs_aack, 1'b0);
        check("rs_rd_byte", obs_rd[0], 8'hC3);
        check("rs_rx_count", rx_q.size() - rx_base, 1);
        check("rs_rx_data", rx_data, 8'h11);
        check("rs_state_post_stop", state, 4'd0);

        // Reset asserted while the slave holds the address ACK low
        do_start();
        for (int i = 7; i >= 0; i--) bit_xfer(i == 0 ? 1'b0 : SLV[i-1], d);
        m_oe = 1'b0;
        #Q;
        scl = 1'b1;
        #(Q/2);
        check("rst_ack_driven", sda, 1'b0);
        reset = 1'b0;
        #1;
        check("rst_sda_released", sda, 1'b1);
        check("rst_state", state, 4'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_tx_req", tx_req, 1'b0);
        #Q;
        reset = 1'b1;
        #(2*Q);

`ifdef I2C_GLITCH_FILTER_EN
        @(posedge clock);
        #1 m_oe = 1'b1;
        @(posedge clock);
        #1 m_oe = 1'b0;
        #200;
        check("glitch_no_start", state, 4'd0);
`endif

        // Randomized transactions against a transaction-level model
        for (int t = 0; t < 16; t++) begin
            a     = $urandom_range(0, 1) ? SLV : 7'($urandom_range(0, 127));
            rw    = 1'($urandom_range(0, 1));
            n     = $urandom_range(1, 3);
            for (int k = 0; k < 4; k++) txb[k] = 8'($urandom);
            match = (a == SLV);
            rx_base  = rx_q.size();
            tx_base  = tx_cnt;
            low_base = low_cnt;
            run_txn(a, rw, n, 1'b1, 1'b1);
            check($sformatf("rnd%0d_addr_ack", t), obs_aack, !match);
            check($sformatf("rnd%0d_busy", t), obs_busy, match);
            check($sformatf("rnd%0d_rx_count", t), rx_q.size() - rx_base, (match && !rw) ? n : 0);
            check($sformatf("rnd%0d_txreq", t), tx_cnt - tx_base, (match && rw) ? n : 0);
            check($sformatf("rnd%0d_state_pre_stop", t), obs_state,
                  (match && !rw) ? 4'd3 : 4'd7);
            for (int k = 0; k < n; k++) begin
                if (rw) begin
                    check($sformatf("rnd%0d_rd%0d", t, k), obs_rd[k], match ? txb[k] : 8'hFF);
                end else begin
                    check($sformatf("rnd%0d_dack%0d", t, k), obs_dack[k], !match);
                    if (match && rx_q.size() > rx_base + k)
                        check($sformatf("rnd%0d_rx%0d", t, k), rx_q[rx_base+k], txb[k]);
                end
            end
            if (!match) check($sformatf("rnd%0d_sda_never_low", t), low_cnt - low_base, 0);
            check($sformatf("rnd%0d_state_post_stop", t), state, 4'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
